// File: rtl/clock_alarm_ctrl.sv
// Timekeeping and alarm controller: owns hh:mm:ss and the alarm hh:mm registers.
// It applies field edits, raises and silences the alarm, and drives the display blink strobe.
module clock_alarm_ctrl #(
  parameter int TICKS_PER_SEC   = 200,
  parameter int ALARM_TIMEOUT_S = 60
) (
  input  logic       clk_out,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_any,
  output logic [4:0] time_hh,
  output logic [5:0] time_mm,
  output logic [5:0] time_ss,
  output logic [4:0] alarm_hh,
  output logic [5:0] alarm_mm,
  output logic       alarm_on,
  output logic       blink
);

  localparam int            CW           = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] TICK_LAST    = CW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] TICK_HALF    = CW'(TICKS_PER_SEC / 2);
  localparam logic [7:0]    TIMEOUT_LAST = 8'(ALARM_TIMEOUT_S - 1);

  localparam logic [2:0] MODE_TIME_HH  = 3'd1;
  localparam logic [2:0] MODE_TIME_MM  = 3'd2;
  localparam logic [2:0] MODE_ALARM_HH = 3'd3;
  localparam logic [2:0] MODE_ALARM_MM = 3'd4;

  logic [CW-1:0] presc_reg, presc_next;
  logic [CW-1:0] blink_cnt_reg, blink_cnt_next;
  logic [7:0]    timeout_reg, timeout_next;
  logic [4:0]    hh_reg, hh_next;
  logic [5:0]    mm_reg, mm_next;
  logic [5:0]    ss_reg, ss_next;
  logic [4:0]    alarm_hh_reg, alarm_hh_next;
  logic [5:0]    alarm_mm_reg, alarm_mm_next;
  logic          alarm_on_reg, alarm_on_next;
  logic          blink_reg, blink_next;

  logic edit_mode, do_up, do_down, tick, trigger, silence;

  // Wrapping +/-1 on a field whose legal range is 0..last.
  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] last,
                                           input logic up);
    if (up) return (v == last) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? last : v - 6'd1;
  endfunction

  always_comb begin
    presc_next     = presc_reg;
    timeout_next   = timeout_reg;
    hh_next        = hh_reg;
    mm_next        = mm_reg;
    ss_next        = ss_reg;
    alarm_hh_next  = alarm_hh_reg;
    alarm_mm_next  = alarm_mm_reg;
    alarm_on_next  = alarm_on_reg;
    tick           = 1'b0;
    trigger        = 1'b0;

    edit_mode = (mode >= MODE_TIME_HH) && (mode <= MODE_ALARM_MM);
    do_up     = btn_up & ~btn_down;
    do_down   = btn_down & ~btn_up;
    silence   = btn_up | btn_down | btn_any | edit_mode;

    blink_cnt_next = (blink_cnt_reg == TICK_LAST) ? '0 : blink_cnt_reg + 1'b1;
    blink_next     = edit_mode ? (blink_cnt_next < TICK_HALF) : 1'b1;

    if (!edit_mode) begin
      if (presc_reg == TICK_LAST) begin
        tick       = 1'b1;
        presc_next = '0;
        if (ss_reg == 6'd59) begin
          ss_next = 6'd0;
          if (mm_reg == 6'd59) begin
            mm_next = 6'd0;
            hh_next = (hh_reg == 5'd23) ? 5'd0 : hh_reg + 5'd1;
          end else begin
            mm_next = mm_reg + 6'd1;
          end
          // Only a minute rollover can arm the alarm, so a pre-existing match never fires.
          trigger = (hh_next == alarm_hh_reg) && (mm_next == alarm_mm_reg);
        end else begin
          ss_next = ss_reg + 6'd1;
        end
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end else if (do_up || do_down) begin
      case (mode)
        MODE_TIME_HH: begin
          hh_next    = 5'(step_wrap({1'b0, hh_reg}, 6'd23, do_up));
          ss_next    = 6'd0;
          presc_next = '0;
        end
        MODE_TIME_MM: begin
          mm_next    = step_wrap(mm_reg, 6'd59, do_up);
          ss_next    = 6'd0;
          presc_next = '0;
        end
        MODE_ALARM_HH: alarm_hh_next = 5'(step_wrap({1'b0, alarm_hh_reg}, 6'd23, do_up));
        MODE_ALARM_MM: alarm_mm_next = step_wrap(alarm_mm_reg, 6'd59, do_up);
        default: ;
      endcase
    end

    // Silence outranks a coincident trigger; a re-trigger restarts the timeout.
    if (silence) begin
      alarm_on_next = 1'b0;
      timeout_next  = 8'd0;
    end else if (trigger) begin
      alarm_on_next = 1'b1;
      timeout_next  = 8'd0;
    end else if (alarm_on_reg && tick) begin
      if (timeout_reg == TIMEOUT_LAST) begin
        alarm_on_next = 1'b0;
        timeout_next  = 8'd0;
      end else begin
        timeout_next = timeout_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      presc_reg     <= '0;
      blink_cnt_reg <= '0;
      timeout_reg   <= 8'd0;
      hh_reg        <= 5'd0;
      mm_reg        <= 6'd0;
      ss_reg        <= 6'd0;
      alarm_hh_reg  <= 5'd0;
      alarm_mm_reg  <= 6'd0;
      alarm_on_reg  <= 1'b0;
      blink_reg     <= 1'b1;
    end else begin
      presc_reg     <= presc_next;
      blink_cnt_reg <= blink_cnt_next;
      timeout_reg   <= timeout_next;
      hh_reg        <= hh_next;
      mm_reg        <= mm_next;
      ss_reg        <= ss_next;
      alarm_hh_reg  <= alarm_hh_next;
      alarm_mm_reg  <= alarm_mm_next;
      alarm_on_reg  <= alarm_on_next;
      blink_reg     <= blink_next;
    end
  end

  assign time_hh  = hh_reg;
  assign time_mm  = mm_reg;
  assign time_ss  = ss_reg;
  assign alarm_hh = alarm_hh_reg;
  assign alarm_mm = alarm_mm_reg;
  assign alarm_on = alarm_on_reg;
  assign blink    = blink_reg;

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Bench for clock_alarm_ctrl: seconds-of-day scoreboard model plus an edit vector table
// and hand-written alarm trigger, silence and async reset sequences.
module tb_clock_alarm_ctrl;
  localparam int T  = 4;
  localparam int TO = 3;

  logic       clk_out = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode = 3'd0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_any = 1'b0;
  logic [4:0] time_hh, alarm_hh;
  logic [5:0] time_mm, time_ss, alarm_mm;
  logic       alarm_on, blink;

  clock_alarm_ctrl #(.TICKS_PER_SEC(T), .ALARM_TIMEOUT_S(TO)) dut (
    .clk_out(clk_out), .rst(rst), .mode(mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_any(btn_any), .time_hh(time_hh), .time_mm(time_mm), .time_ss(time_ss),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_on(alarm_on), .blink(blink)
  );

  always #5 clk_out = ~clk_out;

  typedef struct { logic [31:0] vec; string tag; } sb_t;
  typedef struct {
    logic [2:0] md; logic up, dn, any;
    int hh, mm, ahh, amm, on;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[$];
  int   n_cmp = 0, n_bad = 0, n_txn = 0;

  // Reference model: time as seconds of day, alarm as minute of day.
  int m_sod, m_presc, m_amin, m_on, m_to, m_blk, m_blink;

  function automatic logic [31:0] pack(int hh, int mm, int ss, int ahh, int amm, int on, int bl);
    return {2'b00, 5'(hh), 6'(mm), 6'(ss), 5'(ahh), 6'(amm), 1'(on), 1'(bl)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {2'b00, time_hh, time_mm, time_ss, alarm_hh, alarm_mm, alarm_on, blink};
  endfunction

  task automatic model_reset();
    m_sod = 0; m_presc = 0; m_amin = 0; m_on = 0; m_to = 0; m_blk = 0; m_blink = 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic [2:0] md, input logic u, input logic d, input logic a);
    bit edit, tick, trig;
    int delta, hh, mm;
    edit  = (md >= 3'd1) && (md <= 3'd4);
    delta = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
    tick  = 0;
    trig  = 0;
    if (!edit) begin
      if (m_presc == T - 1) begin
        tick    = 1;
        m_presc = 0;
        m_sod   = (m_sod + 1) % 86400;
        trig    = (m_sod % 60 == 0) && (m_sod / 60 == m_amin);
      end else begin
        m_presc++;
      end
    end else if (delta != 0) begin
      hh = m_sod / 3600;
      mm = (m_sod / 60) % 60;
      case (md)
        3'd1: begin hh = (hh + delta + 24) % 24; m_sod = hh * 3600 + mm * 60; m_presc = 0; end
        3'd2: begin mm = (mm + delta + 60) % 60; m_sod = hh * 3600 + mm * 60; m_presc = 0; end
        3'd3: m_amin = (((m_amin / 60) + delta + 24) % 24) * 60 + m_amin % 60;
        default: m_amin = (m_amin / 60) * 60 + ((m_amin % 60) + delta + 60) % 60;
      endcase
    end
    if (u || d || a || edit) begin
      m_on = 0; m_to = 0;
    end else if (trig) begin
      m_on = 1; m_to = 0;
    end else if (m_on != 0 && tick) begin
      m_to++;
      if (m_to == TO) begin m_on = 0; m_to = 0; end
    end
    m_blk   = (m_blk + 1) % T;
    m_blink = edit ? int'(m_blk < T / 2) : 1;
  endtask

  // One clock transaction: drive at negedge, push expectation, compare after the edge.
  task automatic cycle(input logic [2:0] md, input logic u, input logic d, input logic a,
                       input string tag);
    sb_t e;
    @(negedge clk_out);
    mode = md; btn_up = u; btn_down = d; btn_any = a;
    model_step(md, u, d, a);
    sb_q.push_back('{pack(m_sod / 3600, (m_sod / 60) % 60, m_sod % 60, m_amin / 60,
                          m_amin % 60, m_on, m_blink), tag});
    @(posedge clk_out);
    #1;
    n_txn++;
    $display("txn %0d %s mode=%0d up=%b dn=%b any=%b -> %02d:%02d:%02d alarm %02d:%02d on=%b blink=%b",
             n_txn, tag, md, u, d, a, time_hh, time_mm, time_ss, alarm_hh, alarm_mm, alarm_on, blink);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, dut_vec(), e.vec);
    end
    btn_up = 1'b0; btn_down = 1'b0; btn_any = 1'b0;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(3'd0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic add(input logic [2:0] md, input logic u, input logic d, input logic a,
                     input int hh, input int mm, input int ahh, input int amm, input int on);
    vec_t v;
    v.md = md; v.up = u; v.dn = d; v.any = a;
    v.hh = hh; v.mm = mm; v.ahh = ahh; v.amm = amm; v.on = on;
    tbl.push_back(v);
  endtask

  task automatic apply_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      cycle(tbl[i].md, tbl[i].up, tbl[i].dn, tbl[i].any, $sformatf("tbl%0d_model", i));
      check($sformatf("tbl%0d", i), dut_vec() >> 1,
            pack(tbl[i].hh, tbl[i].mm, 0, tbl[i].ahh, tbl[i].amm, tbl[i].on, 0) >> 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // md, up, dn, any, expected hh, mm, alarm hh, alarm mm, alarm_on
    add(3'd1, 0, 1, 0, 23,  1,  0,  0, 0);
    add(3'd2, 0, 1, 0, 23,  0,  0,  0, 0);
    add(3'd2, 0, 1, 0, 23, 59,  0,  0, 0);
    add(3'd1, 1, 0, 0,  1,  0,  0,  0, 0);
    add(3'd1, 1, 0, 0,  2,  0,  0,  0, 0);
    add(3'd1, 1, 0, 0,  3,  0,  0,  0, 0);
    add(3'd1, 1, 0, 0,  4,  0,  0,  0, 0);
    add(3'd1, 1, 0, 0,  5,  0,  0,  0, 0);
    add(3'd2, 0, 1, 0,  5, 59,  0,  0, 0);
    add(3'd2, 1, 0, 0,  5,  0,  0,  0, 0);
    add(3'd1, 0, 1, 0,  4,  0,  0,  0, 0);
    add(3'd1, 0, 1, 0,  3,  0,  0,  0, 0);
    add(3'd1, 0, 1, 0,  2,  0,  0,  0, 0);
    add(3'd1, 0, 1, 0,  1,  0,  0,  0, 0);
    add(3'd1, 0, 1, 0,  0,  0,  0,  0, 0);
    add(3'd1, 0, 1, 0, 23,  0,  0,  0, 0);
    add(3'd1, 1, 1, 0, 23,  0,  0,  0, 0);
    add(3'd2, 1, 1, 0, 23,  0,  0,  0, 0);
    add(3'd3, 0, 1, 0, 23,  0, 23,  0, 0);
    add(3'd3, 1, 0, 0, 23,  0,  0,  0, 0);
    add(3'd4, 0, 1, 0, 23,  0,  0, 59, 0);
    add(3'd4, 1, 0, 0, 23,  0,  0,  0, 0);
    add(3'd4, 1, 0, 0, 23,  0,  0,  1, 0);
    add(3'd4, 1, 0, 0, 23,  0,  0,  2, 0);
    add(3'd1, 1, 0, 0,  0,  0,  0,  2, 0);
    add(3'd2, 1, 0, 0,  0,  1,  0,  2, 0);
    add(3'd3, 1, 1, 0,  0,  1,  0,  2, 0);

    // Reset held across two edges.
    model_reset();
    repeat (2) @(posedge clk_out);
    #1;
    check("reset_state", dut_vec(), 32'h1);
    rst = 1'b0;

    // Free run for one minute.
    run(T, "run_first_sec");
    check("first_second", {26'd0, time_ss}, 32'd1);
    run(T * 60 - T, "run");
    check("one_minute", dut_vec(), pack(0, 1, 0, 0, 0, 0, 1));

    // Edit to 23:59, then day wrap; alarm 00:00 matches the wrapped time.
    apply_table(0, 2);
    run(T * 60, "day_wrap");
    check("day_wrap", dut_vec(), pack(0, 0, 0, 0, 0, 1, 1));

    // Edit wrap, carry isolation, simultaneous buttons, alarm edits.
    apply_table(3, tbl.size() - 1);

    // Alarm 00:02, time 00:01:00: trigger then exact timeout.
    run(T * 60 - 1, "pre_trigger");
    check("no_early_trigger", {31'd0, alarm_on}, 32'd0);
    run(1, "trigger");
    check("trigger_edge", dut_vec(), pack(0, 2, 0, 0, 2, 1, 1));
    run(T * TO - 1, "alarm_hold");
    check("alarm_still_on", {31'd0, alarm_on}, 32'd1);
    run(1, "timeout");
    check("timeout_edge", {31'd0, alarm_on}, 32'd0);

    // Silence on the trigger edge wins.
    cycle(3'd2, 1'b0, 1'b1, 1'b0, "set_0001");
    run(T * 60 - 1, "pre_trigger2");
    cycle(3'd0, 1'b0, 1'b0, 1'b1, "any_on_trigger");
    check("silence_priority", dut_vec(), pack(0, 2, 0, 0, 2, 0, 1));

    // A fresh trigger cleared by leaving run mode.
    cycle(3'd2, 1'b0, 1'b1, 1'b0, "set_0001b");
    run(T * 60, "trigger3");
    check("trigger3_on", {31'd0, alarm_on}, 32'd1);
    cycle(3'd3, 1'b0, 1'b0, 1'b0, "mode_exit");
    check("mode_exit_clears", {31'd0, alarm_on}, 32'd0);

    // Async reset between edges while the alarm is sounding.
    cycle(3'd2, 1'b0, 1'b1, 1'b0, "set_0001c");
    run(T * 60, "trigger4");
    @(negedge clk_out);
    mode = 3'd4;
    #1;
    check("alarm_before_rst", {31'd0, alarm_on}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset", dut_vec(), 32'h1);
    model_reset();
    @(posedge clk_out);
    #1;
    rst = 1'b0;
    run(2 * T, "after_reset");
    check("after_reset_time", dut_vec(), pack(0, 0, 2, 0, 0, 0, 1));

    if (sb_q.size() != 0) check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
